// File: rtl/tdc_pkg.sv
// Shared types and helpers for the delay-line TDC phase decoder.
// Holds the divider state encoding, the bubble-correction majority vote and the width helpers.
package tdc_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StDiv,
    StDone
  } div_state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Width of a tap position / period in delay-cell units.
  function automatic int unsigned per_width(input int unsigned ntdc);
    return $clog2(ntdc) + 1;
  endfunction

  function automatic int unsigned recip_width(input int unsigned ntdc, input int unsigned frac_w);
    return frac_w + per_width(ntdc);
  endfunction

endpackage

// File: rtl/tdc_recip_div.sv
// Serial restoring divider computing floor(2**Q_W / divisor), one quotient bit per cycle.
// Result is presented for one cycle in StDone; the caller guarantees divisor >= 2.
module tdc_recip_div
  import tdc_pkg::*;
#(
  parameter int unsigned DIV_W = 7,
  parameter int unsigned Q_W   = 17
) (
  input  logic             ref_clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DIV_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [Q_W-1:0]   quotient
);

  localparam int unsigned CNT_W = $clog2(Q_W);

  div_state_t       state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] rem_q, rem_d;
  logic [Q_W-1:0]   quo_q, quo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DIV_W:0]   rem_sh;
  logic [DIV_W:0]   rem_sub;

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    busy    = (state_q != StIdle);
    done    = 1'b0;
    rem_sh  = {rem_q, 1'b0};
    rem_sub = rem_sh - {1'b0, div_q};
    case (state_q)
      StIdle: begin
        if (start) begin
          div_d   = divisor;
          // Leading numerator bit; its quotient bit is always 0 since divisor >= 2.
          rem_d   = DIV_W'(1);
          quo_d   = '0;
          cnt_d   = '0;
          state_d = StDiv;
        end
      end
      StDiv: begin
        if (rem_sh >= {1'b0, div_q}) begin
          rem_d = rem_sub[DIV_W-1:0];
          quo_d = {quo_q[Q_W-2:0], 1'b1};
        end else begin
          rem_d = rem_sh[DIV_W-1:0];
          quo_d = {quo_q[Q_W-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(Q_W - 1)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge ref_clk) begin
    if (rst) begin
      state_q <= StIdle;
      div_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
    end
  end

  assign quotient = quo_q;

endmodule

// File: rtl/tdc_phase_decoder.sv
// Delay-line TDC post-processor: bubble fix, edge search, period averaging and
// normalised phase = edge_pos / period via a serially computed reciprocal.
module tdc_phase_decoder
  import tdc_pkg::*;
#(
  parameter int unsigned NTDC     = 64,
  parameter int unsigned FRAC_W   = 10,
  parameter int unsigned AVG_LOG  = 4,
  parameter int unsigned EDGE_SEL = 0,
  localparam int unsigned PER_W   = per_width(NTDC),
  localparam int unsigned RECIP_W = recip_width(NTDC, FRAC_W)
) (
  input  logic              ref_clk,
  input  logic              rst,
  input  logic              en,
  input  logic [NTDC-1:0]   sampled_tdc,
  output logic [FRAC_W-1:0] phase_frac,
  output logic              phase_valid,
  output logic              no_edge,
  output logic [PER_W-1:0]  period_avg,
  output logic              period_valid
);

  localparam int unsigned ACC_W  = PER_W + AVG_LOG;
  localparam int unsigned CNT_W  = AVG_LOG + 1;
  localparam int unsigned AVG_N  = 1 << AVG_LOG;
  localparam int unsigned PROD_W = PER_W + RECIP_W;

  // S1: raw sample capture
  logic            s1_valid_q;
  logic [NTDC-1:0] s1_word_q;

  always_ff @(posedge ref_clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_word_q  <= '0;
    end else begin
      s1_valid_q <= en;
      if (en) begin
        s1_word_q <= sampled_tdc;
      end
    end
  end

  // Bubble correction with the word replicated at both ends.
  logic [NTDC+1:0] word_ext;
  logic [NTDC-1:0] clean;

  always_comb begin
    word_ext = {s1_word_q[NTDC-1], s1_word_q, s1_word_q[0]};
    clean    = '0;
    for (int i = 0; i < NTDC; i++) begin
      clean[i] = maj3(word_ext[i], word_ext[i+1], word_ext[i+2]);
    end
  end

  // Descending scan so the lowest matching tap wins.
  logic [PER_W-1:0] rise_pos_d, fall_pos_d;
  logic             rise_found_d, fall_found_d;

  always_comb begin
    rise_pos_d   = '0;
    fall_pos_d   = '0;
    rise_found_d = 1'b0;
    fall_found_d = 1'b0;
    for (int i = NTDC - 1; i >= 1; i--) begin
      if (!clean[i-1] && clean[i]) begin
        rise_found_d = 1'b1;
        rise_pos_d   = PER_W'(i);
      end
      if (clean[i-1] && !clean[i]) begin
        fall_found_d = 1'b1;
        fall_pos_d   = PER_W'(i);
      end
    end
  end

  // S2: edge positions
  logic             s2_valid_q;
  logic [PER_W-1:0] rise_pos_q, fall_pos_q;
  logic             rise_found_q, fall_found_q;

  always_ff @(posedge ref_clk) begin
    if (rst) begin
      s2_valid_q   <= 1'b0;
      rise_pos_q   <= '0;
      fall_pos_q   <= '0;
      rise_found_q <= 1'b0;
      fall_found_q <= 1'b0;
    end else begin
      s2_valid_q   <= s1_valid_q;
      rise_pos_q   <= rise_pos_d;
      fall_pos_q   <= fall_pos_d;
      rise_found_q <= s1_valid_q & rise_found_d;
      fall_found_q <= s1_valid_q & fall_found_d;
    end
  end

  // Period estimate and averaging
  logic [PER_W-1:0] edge_diff, period_smp;
  logic [ACC_W-1:0] acc_q, acc_d, acc_sum;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PER_W-1:0] period_avg_q, period_avg_d;
  logic             avg_req;

  always_comb begin
    edge_diff    = (rise_pos_q > fall_pos_q) ? (rise_pos_q - fall_pos_q)
                                             : (fall_pos_q - rise_pos_q);
    period_smp   = PER_W'({edge_diff, 1'b0});
    acc_sum      = acc_q + ACC_W'(period_smp);
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    period_avg_d = period_avg_q;
    avg_req      = 1'b0;
    if (s2_valid_q && rise_found_q && fall_found_q) begin
      if (cnt_q == CNT_W'(AVG_N - 1)) begin
        period_avg_d = acc_sum[ACC_W-1:AVG_LOG];
        acc_d        = '0;
        cnt_d        = '0;
        avg_req      = 1'b1;
      end else begin
        acc_d = acc_sum;
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Divider launch; a request arriving while busy replaces any older pending one.
  logic               div_start, div_busy, div_done;
  logic [PER_W-1:0]   div_divisor;
  logic [RECIP_W-1:0] div_quot;
  logic               pend_q, pend_d;
  logic [PER_W-1:0]   pend_div_q, pend_div_d;

  always_comb begin
    div_start   = 1'b0;
    div_divisor = pend_div_q;
    pend_d      = pend_q;
    pend_div_d  = pend_div_q;
    if (avg_req && (period_avg_d >= PER_W'(2))) begin
      if (div_busy) begin
        pend_d     = 1'b1;
        pend_div_d = period_avg_d;
      end else begin
        div_start   = 1'b1;
        div_divisor = period_avg_d;
        pend_d      = 1'b0;
      end
    end else if (pend_q && !div_busy) begin
      div_start = 1'b1;
      pend_d    = 1'b0;
    end
  end

  tdc_recip_div #(
    .DIV_W (PER_W),
    .Q_W   (RECIP_W)
  ) u_div (
    .ref_clk  (ref_clk),
    .rst      (rst),
    .start    (div_start),
    .divisor  (div_divisor),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quot)
  );

  // S3 registers, averager state and reciprocal
  logic               s3_valid_q, s3_found_q;
  logic [PER_W-1:0]   s3_pos_q;
  logic [RECIP_W-1:0] recip_q;
  logic               period_valid_q;

  always_ff @(posedge ref_clk) begin
    if (rst) begin
      s3_valid_q     <= 1'b0;
      s3_found_q     <= 1'b0;
      s3_pos_q       <= '0;
      acc_q          <= '0;
      cnt_q          <= '0;
      period_avg_q   <= '0;
      pend_q         <= 1'b0;
      pend_div_q     <= '0;
      recip_q        <= '0;
      period_valid_q <= 1'b0;
    end else begin
      s3_valid_q   <= s2_valid_q;
      s3_found_q   <= (EDGE_SEL != 0) ? fall_found_q : rise_found_q;
      s3_pos_q     <= (EDGE_SEL != 0) ? fall_pos_q : rise_pos_q;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      period_avg_q <= period_avg_d;
      pend_q       <= pend_d;
      pend_div_q   <= pend_div_d;
      if (div_done) begin
        recip_q        <= div_quot;
        period_valid_q <= 1'b1;
      end
    end
  end

  // S4: phase = pos * recip, rescaled and saturated
  logic [PROD_W-1:0] prod, prod_sh;
  logic [FRAC_W-1:0] phase_d;
  logic              phase_valid_d, no_edge_d;
  logic [FRAC_W-1:0] phase_frac_q;
  logic              phase_valid_q, no_edge_q;

  always_comb begin
    prod          = PROD_W'(s3_pos_q) * PROD_W'(recip_q);
    prod_sh       = prod >> PER_W;
    phase_d       = (|prod_sh[PROD_W-1:FRAC_W]) ? '1 : prod_sh[FRAC_W-1:0];
    phase_valid_d = s3_valid_q & s3_found_q & period_valid_q;
    no_edge_d     = s3_valid_q & ~s3_found_q;
  end

  always_ff @(posedge ref_clk) begin
    if (rst) begin
      phase_frac_q  <= '0;
      phase_valid_q <= 1'b0;
      no_edge_q     <= 1'b0;
    end else begin
      phase_valid_q <= phase_valid_d;
      no_edge_q     <= no_edge_d;
      if (phase_valid_d) begin
        phase_frac_q <= phase_d;
      end
    end
  end

  assign phase_frac   = phase_frac_q;
  assign phase_valid  = phase_valid_q;
  assign no_edge      = no_edge_q;
  assign period_avg   = period_avg_q;
  assign period_valid = period_valid_q;

endmodule

// File: tb/tb_tdc_phase_decoder.sv
// Directed bench for tdc_phase_decoder: one instance per edge selection, shared stimulus.
module tb_tdc_phase_decoder;

  localparam int unsigned NTDC    = 64;
  localparam int unsigned FRAC_W  = 10;
  localparam int unsigned PER_W   = 7;
  localparam int unsigned RECIP_W = 17;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic [NTDC-1:0]   word;
  logic [FRAC_W-1:0] pf0, pf1;
  logic              pv0, pv1, ne0, ne1, pval0, pval1;
  logic [PER_W-1:0]  pa0, pa1;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  tdc_phase_decoder #(
    .NTDC     (NTDC),
    .FRAC_W   (FRAC_W),
    .AVG_LOG  (4),
    .EDGE_SEL (0)
  ) u_dut0 (
    .ref_clk      (clk),
    .rst          (rst),
    .en           (en),
    .sampled_tdc  (word),
    .phase_frac   (pf0),
    .phase_valid  (pv0),
    .no_edge      (ne0),
    .period_avg   (pa0),
    .period_valid (pval0)
  );

  tdc_phase_decoder #(
    .NTDC     (NTDC),
    .FRAC_W   (FRAC_W),
    .AVG_LOG  (4),
    .EDGE_SEL (1)
  ) u_dut1 (
    .ref_clk      (clk),
    .rst          (rst),
    .en           (en),
    .sampled_tdc  (word),
    .phase_frac   (pf1),
    .phase_valid  (pv1),
    .no_edge      (ne1),
    .period_avg   (pa1),
    .period_valid (pval1)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [NTDC-1:0] band(input int lo, input int hi);
    logic [NTDC-1:0] w;
    w = '0;
    for (int i = lo; i < hi; i++) w[i] = 1'b1;
    return w;
  endfunction

  task automatic send(input logic [NTDC-1:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      en   = 1'b1;
      word = w;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      en = 1'b0;
    end
  endtask

  // One sample, then look at the outputs exactly four cycles later.
  task automatic probe(input string tag, input logic [NTDC-1:0] w, input int exp_pv,
                       input int exp_ne, input int exp_pf0, input int exp_pf1);
    send(w, 1);
    idle(4);
    check_eq({tag, "_pv"}, pv0, exp_pv);
    check_eq({tag, "_ne"}, ne0, exp_ne);
    check_eq({tag, "_pv1"}, pv1, exp_pv);
    if (exp_pv != 0) begin
      check_eq({tag, "_pf0"}, pf0, exp_pf0);
      check_eq({tag, "_pf1"}, pf1, exp_pf1);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    en  = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [NTDC-1:0] w40, w20, wbub, wzero;
  logic [7:0]      pat;
  int              cyc;

  initial begin
    w40   = band(10, 30);
    w20   = band(10, 20);
    wbub  = w40;
    wbub[20] = 1'b0;
    wzero = '0;
    pat   = 8'b1011_0010;
    rst   = 1'b1;
    en    = 1'b0;
    word  = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check_eq("rst_pf", pf0, 0);
    check_eq("rst_pv", pv0, 0);
    check_eq("rst_ne", ne0, 0);
    check_eq("rst_pa", pa0, 0);
    check_eq("rst_pval", pval0, 0);

    // Period 40 average; reciprocal 131072/40 = 3276.
    send(w40, 16);
    @(negedge clk);
    en  = 1'b0;
    cyc = 1;
    while (!pval0 && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("t1_pval_lat", cyc, 3 + RECIP_W + 1);
    check_eq("t1_pa0", pa0, 40);
    check_eq("t1_pa1", pa1, 40);
    check_eq("t1_pval1", pval1, 1);
    probe("t1", w40, 1, 0, 255, 767);

    probe("t2_bubble", wbub, 1, 0, 255, 767);

    probe("t3_zero", wzero, 0, 1, 0, 0);
    check_eq("t3_ne1", ne1, 1);

    // Two period-40 probes already counted, zero word not: 14 x 20 completes (80+280)/16 = 22.
    send(w20, 14);
    idle(30);
    check_eq("t3_cnt_pa", pa0, 22);
    // 131072/22 = 5957: 10*5957>>7 = 465, 30*5957>>7 = 1396 saturates.
    probe("t3_sat", w40, 1, 0, 465, 1023);

    // New request during an active divide is held and run afterwards.
    do_reset();
    send(w40, 16);
    send(w20, 16);
    idle(60);
    check_eq("t4_pa", pa0, 20);
    check_eq("t4_pval", pval0, 1);
    probe("t4", w20, 1, 0, 511, 1023);

    // Reset while the divider is running.
    send(w40, 16);
    idle(5);
    check_eq("t5_busy", u_dut0.u_div.busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("t5_pf", pf0, 0);
    check_eq("t5_pv", pv0, 0);
    check_eq("t5_ne", ne0, 0);
    check_eq("t5_pa", pa0, 0);
    check_eq("t5_pval", pval0, 0);
    check_eq("t5_fsm", u_dut0.u_div.state_q, 0);
    idle(30);
    check_eq("t5_pval_held", pval0, 0);

    // Valid pulses track the en pattern four cycles later.
    send(w40, 16);
    idle(25);
    check_eq("t6_pval", pval1, 1);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i >= 4) begin
        check_eq($sformatf("t6_pv1_%0d", i), pv1, pat[i-4]);
        check_eq($sformatf("t6_pv0_%0d", i), pv0, pat[i-4]);
      end
      en   = (i < 8) ? pat[i] : 1'b0;
      word = w40;
    end
    check_eq("t6_pf1", pf1, 767);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
